// File: rtl/psum_accum.sv
// psum_accum: partial-sum accumulation buffer.
// A pass pulls N vectors from a first-word-fall-through FIFO and either
// overwrites or saturating-adds them into a depth-entry buffer. A last pass
// then streams the ReLU of every entry out through a valid/ready port.
module psum_accum #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [7:0]             num_vec,
    input  logic                   first_pass,
    input  logic                   last_pass,
    input  logic                   ofifo_valid,
    input  logic [psum_bw*col-1:0] ofifo_out,
    output logic                   ofifo_rd,
    output logic                   out_valid,
    output logic [psum_bw*col-1:0] out_data,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done
);
    localparam int IW = (depth > 1) ? $clog2(depth) : 1;
    localparam int NW = $clog2(depth + 1);

    localparam logic [psum_bw-1:0] SAT_POS = {1'b0, {(psum_bw-1){1'b1}}};
    localparam logic [psum_bw-1:0] SAT_NEG = {1'b1, {(psum_bw-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [NW-1:0] n_q, n_d, n_start;
    logic          fp_q, fp_d;
    logic          lp_q, lp_d;
    logic          idx_last;

    // Accumulation buffer; contents are not reset (the first pass overwrites).
    logic [col-1:0][psum_bw-1:0] acc_buf [depth];

    logic [col-1:0][psum_bw-1:0] cur_vec;
    logic [col-1:0][psum_bw-1:0] in_vec;
    logic [col-1:0][psum_bw-1:0] wr_vec;
    logic [col-1:0][psum_bw-1:0] relu_vec;

    assign cur_vec  = acc_buf[idx_q];
    assign in_vec   = ofifo_out;
    assign idx_last = (NW'(idx_q) == NW'(n_q - NW'(1)));

    // The FIFO is popped only in ACCUM while it holds data; reset kills the pop
    // in the same cycle so an abandoned pass never consumes a vector.
    assign ofifo_rd = (state_q == ACCUM) && ofifo_valid && !reset;

    // Drain data is decoded straight from the buffer so it stays put while stalled.
    assign out_data = out_valid ? relu_vec : '0;

    // Per-lane datapath: signed saturating add for the write-back, ReLU for the drain.
    for (genvar k = 0; k < col; k++) begin : g_lane
        logic [psum_bw-1:0] a, d, s;
        logic               pos_ovf, neg_ovf;

        assign a       = cur_vec[k];
        assign d       = in_vec[k];
        assign s       = a + d;
        // Overflow only when both operands share a sign the sum does not.
        assign pos_ovf = ~a[psum_bw-1] & ~d[psum_bw-1] &  s[psum_bw-1];
        assign neg_ovf =  a[psum_bw-1] &  d[psum_bw-1] & ~s[psum_bw-1];

        assign wr_vec[k]   = fp_q    ? d       :
                             pos_ovf ? SAT_POS :
                             neg_ovf ? SAT_NEG : s;
        assign relu_vec[k] = a[psum_bw-1] ? '0 : a;
    end

    // Effective vector count: the request is clipped to the buffer depth.
    always_comb begin
        n_start = NW'(num_vec);
        if (int'(num_vec) > depth) begin
            n_start = NW'(depth);
        end
    end

    // Next-state and index control for the pass sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        n_d     = n_q;
        fp_d    = fp_q;
        lp_d    = lp_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    n_d     = n_start;
                    fp_d    = first_pass;
                    lp_d    = last_pass;
                    idx_d   = '0;
                    state_d = (n_start == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (ofifo_valid) begin
                    if (idx_last) begin
                        idx_d   = '0;
                        state_d = lp_q ? DRAIN : DONE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (idx_last) begin
                        idx_d   = '0;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state plus registered status outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            n_q       <= '0;
            fp_q      <= 1'b0;
            lp_q      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            n_q       <= n_d;
            fp_q      <= fp_d;
            lp_q      <= lp_d;
            busy      <= (state_d != IDLE);
            done      <= (state_d == DONE);
            out_valid <= (state_d == DRAIN);
        end
    end

    // Buffer write-back on every FIFO pop; drains only read.
    always_ff @(posedge clk) begin
        if (ofifo_rd) begin
            acc_buf[idx_q] <= wr_vec;
        end
    end

endmodule

// File: tb/tb_psum_accum.sv
// tb_psum_accum: randomized and directed stimulus against a transaction-level
// model of the accumulation buffer, checked every cycle.
module tb_psum_accum;
    localparam int COL   = 8;
    localparam int PBW   = 16;
    localparam int DEPTH = 64;
    localparam int VW    = COL * PBW;
    localparam int SMAX  = (1 << (PBW - 1)) - 1;
    localparam int SMIN  = -(1 << (PBW - 1));

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    num_vec = '0;
    logic          first_pass = 1'b0;
    logic          last_pass = 1'b0;
    logic          ofifo_valid = 1'b0;
    logic [VW-1:0] ofifo_out = '0;
    logic          ofifo_rd;
    logic          out_valid;
    logic [VW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic          busy;
    logic          done;

    psum_accum #(.col(COL), .psum_bw(PBW), .depth(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_vec    (num_vec),
        .first_pass (first_pass),
        .last_pass  (last_pass),
        .ofifo_valid(ofifo_valid),
        .ofifo_out  (ofifo_out),
        .ofifo_rd   (ofifo_rd),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [VW-1:0] fifo_q[$];
    logic [VW-1:0] exp_q[$];
    logic [VW-1:0] got_q[$];
    int            valid_pat[$];
    int            ready_pat[$];
    int            rd_cycles[$];
    int            vprob = 100;
    int            rprob = 100;
    int            mbuf[DEPTH][COL];
    bit            m_accum = 0, m_drain = 0, done_pend = 0, m_fp = 0, m_lp = 0;
    bit            rd_seen = 0, hold_prev = 0;
    int            m_n = 0, m_reads = 0, pass_cyc = 0;
    logic [VW-1:0] prev_data = '0;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] mkvec(input int lane, input int val);
        logic [VW-1:0] v;
        v = '0;
        v[lane*PBW +: PBW] = PBW'(val);
        return v;
    endfunction

    function automatic int lane_of(input logic [VW-1:0] v, input int k);
        logic [PBW-1:0] t;
        t = v[k*PBW +: PBW];
        return int'($signed(t));
    endfunction

    function automatic int sat(input int a, input int b);
        int s;
        s = a + b;
        if (s > SMAX) s = SMAX;
        if (s < SMIN) s = SMIN;
        return s;
    endfunction

    function automatic logic [VW-1:0] relu_entry(input int i);
        logic [VW-1:0] v;
        v = '0;
        for (int k = 0; k < COL; k++)
            if (mbuf[i][k] > 0) v[k*PBW +: PBW] = PBW'(mbuf[i][k]);
        return v;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Compare process: every cycle, DUT outputs against the pass model.
    always @(negedge clk) begin : cmp
        bit            exp_rd, dn_nxt;
        logic [VW-1:0] ev, hv;
        exp_rd = m_accum && ofifo_valid && !reset;
        chk("ofifo_rd", ofifo_rd, exp_rd);
        chk("busy", busy, m_accum || m_drain || done_pend);
        chk("done", done, done_pend);
        chk("out_valid", out_valid, m_drain);
        ev = (m_drain && exp_q.size() > 0) ? exp_q[0] : '0;
        chk("out_data", out_data, ev);
        if (hold_prev) begin
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_data", out_data, prev_data);
        end
        hold_prev = out_valid && !out_ready && !reset;
        prev_data = out_data;
        rd_seen   = ofifo_rd;
        if (ofifo_rd) rd_cycles.push_back(pass_cyc);
        dn_nxt = 0;
        if (reset) begin
            m_accum   = 0;
            m_drain   = 0;
            hold_prev = 0;
            exp_q.delete();
        end else begin
            if (m_drain && out_ready && exp_q.size() > 0) begin
                got_q.push_back(out_data);
                exp_q.delete(0);
                if (exp_q.size() == 0) begin
                    m_drain = 0;
                    dn_nxt  = 1;
                end
            end
            if (exp_rd && fifo_q.size() > 0) begin
                hv = fifo_q[0];
                for (int k = 0; k < COL; k++)
                    mbuf[m_reads][k] = m_fp ? lane_of(hv, k) : sat(mbuf[m_reads][k], lane_of(hv, k));
                m_reads++;
                if (m_reads == m_n) begin
                    m_accum = 0;
                    if (m_lp) begin
                        for (int i = 0; i < m_n; i++) exp_q.push_back(relu_entry(i));
                        m_drain = 1;
                    end else begin
                        dn_nxt = 1;
                    end
                end
            end
        end
        done_pend = dn_nxt;
        pass_cyc++;
    end

    // FIFO and downstream driver, updated just after each rising edge.
    always @(posedge clk) begin : drv
        bit g;
        #2;
        if (rd_seen && fifo_q.size() > 0) fifo_q.delete(0);
        if (m_accum && valid_pat.size() > 0) g = (valid_pat.pop_front() != 0);
        else g = ($urandom_range(1, 100) <= vprob);
        ofifo_valid = g && (fifo_q.size() > 0);
        ofifo_out   = (fifo_q.size() > 0) ? fifo_q[0] : rand_vec();
        if (m_drain && ready_pat.size() > 0) out_ready = (ready_pat.pop_front() != 0);
        else out_ready = ($urandom_range(1, 100) <= rprob);
    end

    task automatic begin_pass(input int nv, input bit fp, input bit lp);
        @(posedge clk); #1;
        start      = 1'b1;
        num_vec    = 8'(nv);
        first_pass = fp;
        last_pass  = lp;
        @(posedge clk); #1;
        start      = 1'b0;
        num_vec    = 8'($urandom);
        first_pass = 1'($urandom);
        last_pass  = 1'($urandom);
        m_n      = (nv > DEPTH) ? DEPTH : nv;
        m_fp     = fp;
        m_lp     = lp;
        m_reads  = 0;
        pass_cyc = 1;
        rd_cycles.delete();
        got_q.delete();
        if (m_n == 0) done_pend = 1;
        else m_accum = 1;
    endtask

    task automatic wait_done(input int k0, output int dk);
        dk = 0;
        for (int k = k0; k <= 4000; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dk = k;
                break;
            end
        end
        checks++;
        if (dk == 0) begin
            errors++;
            $display("FAIL done_timeout actual=0 required=1");
        end
    endtask

    task automatic run(input int nv, input bit fp, input bit lp, output int dk);
        begin_pass(nv, fp, lp);
        wait_done(1, dk);
    endtask

    initial begin
        int dk, n, amt;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);

        // Two vectors, last pass: lane0 5 then -7 drains as 5 then 0.
        fifo_q.push_back(mkvec(0, 5));
        fifo_q.push_back(mkvec(0, -7));
        run(2, 1, 1, dk);
        chk("t1_done_cycle", dk, 5);
        chk("t1_reads", rd_cycles.size(), 2);
        chk("t1_drained", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("t1_lane0_a", lane_of(got_q[0], 0), 5);
            chk("t1_lane0_b", lane_of(got_q[1], 0), 0);
        end

        // Three passes accumulating into lane3, then the same with saturation.
        for (int s = 0; s < 2; s++) begin
            amt = (s == 0) ? 10000 : 20000;
            for (int p = 0; p < 3; p++) begin
                fifo_q.push_back(mkvec(3, amt));
                run(1, p == 0, p == 2, dk);
                chk("t2_done_cycle", dk, (p == 2) ? 3 : 2);
            end
            chk("t2_drained", got_q.size(), 1);
            if (got_q.size() == 1) begin
                chk("t2_lane3", lane_of(got_q[0], 3), (s == 0) ? 30000 : 32767);
                chk("t2_lane0", lane_of(got_q[0], 0), 0);
            end
        end

        // FIFO valid 1,0,0,1: pops only in cycles 1 and 4.
        fifo_q.push_back(rand_vec());
        fifo_q.push_back(rand_vec());
        valid_pat = '{1, 0, 0, 1};
        run(2, 1, 0, dk);
        chk("t3_done_cycle", dk, 5);
        chk("t3_reads", rd_cycles.size(), 2);
        if (rd_cycles.size() == 2) begin
            chk("t3_rd_cyc0", rd_cycles[0], 1);
            chk("t3_rd_cyc1", rd_cycles[1], 4);
        end

        // Drain held off by out_ready low for three cycles.
        repeat (3) fifo_q.push_back(rand_vec());
        ready_pat = '{0, 0, 0};
        run(3, 1, 1, dk);
        chk("t4_done_cycle", dk, 10);
        chk("t4_drained", got_q.size(), 3);

        // Reset after one of four vectors, then an empty pass.
        repeat (4) fifo_q.push_back(rand_vec());
        begin_pass(4, 1, 1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("t5_busy", busy, 1'b0);
        chk("t5_ofifo_rd", ofifo_rd, 1'b0);
        chk("t5_reads_before_rst", m_reads, 1);
        run(0, 1, 0, dk);
        chk("t5_done_cycle", dk, 1);
        chk("t5_zero_reads", rd_cycles.size(), 0);
        fifo_q.delete();

        // num_vec beyond depth, with a start pulsed mid-pass.
        repeat (200) fifo_q.push_back(rand_vec());
        begin_pass(200, 1, 1);
        @(posedge clk); #1;
        start = 1'b1; num_vec = 8'd5; first_pass = 1'b0; last_pass = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(3, dk);
        chk("t6_done_cycle", dk, 2 * DEPTH + 1);
        chk("t6_reads", rd_cycles.size(), DEPTH);
        chk("t6_drained", got_q.size(), DEPTH);
        fifo_q.delete();

        // Random passes with random FIFO and downstream stalls.
        for (int p = 0; p < 20; p++) begin
            bit fp, lp;
            n     = $urandom_range(0, 72);
            fp    = 1'($urandom);
            lp    = 1'($urandom);
            vprob = $urandom_range(40, 100);
            rprob = $urandom_range(40, 100);
            for (int i = 0; i < ((n > DEPTH) ? DEPTH : n) + $urandom_range(0, 2); i++)
                fifo_q.push_back(rand_vec());
            run(n, fp, lp, dk);
            chk("rnd_reads", rd_cycles.size(), (n > DEPTH) ? DEPTH : n);
            if (lp) chk("rnd_drained", got_q.size(), (n > DEPTH) ? DEPTH : n);
        end

        vprob = 100;
        rprob = 100;
        fifo_q.delete();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
